wb_rr_arb: RTL and testbench
============================

WB_RR_ARB -- requirements
Module: wb_rr_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the slave no-response limit in clk_i cycles (range 1..255).
REQ-002 Port clk_i, input, 1, the single clock; all state changes on the rising edge.
REQ-003 Port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-004 Port m_wb_cyc_i, input, 3, per-master bus-cycle request; bit n is master n.
REQ-005 Port m_wb_stb_i, input, 3, per-master strobe.
REQ-006 Port m_wb_we_i, input, 3, per-master write enable.
REQ-007 Port m_wb_adr_i, input, 96, packed addresses; master n occupies [32n+31:32n].
REQ-008 Port m_wb_dat_i, input, 96, packed write data, same packing as addresses.
REQ-009 Port m_wb_sel_i, input, 12, packed byte selects; master n occupies [4n+3:4n].
REQ-010 Port m_wb_dat_o, output, 32, read data broadcast to all masters.
REQ-011 Port m_wb_ack_o, output, 3, per-master acknowledge.
REQ-012 Port m_wb_err_o, output, 3, per-master error.
REQ-013 Ports s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, outputs, 1 each, slave bus control.
REQ-014 Ports s_wb_adr_o and s_wb_dat_o, outputs, 32 each, slave address and write data.
REQ-015 Port s_wb_sel_o, output, 4, slave byte selects.
REQ-016 Ports s_wb_dat_i, input, 32, and s_wb_ack_i and s_wb_err_i, inputs, 1 each, slave response.
REQ-017 Port grant_o, output, 2, owning master index (0..2); 3 means no owner.

Function
REQ-018 Two states. IDLE: no owner. OWN: one master owns the slave.
REQ-019 In IDLE with any m_wb_cyc_i bit set, the arbiter picks round-robin, starting at (last_grant+1) mod 3, registers the winner and enters OWN; request-to-slave latency is 1 cycle.
REQ-020 In OWN, the owner's cyc, stb, we, adr, dat and sel pass combinationally to the slave.
REQ-021 In IDLE, all s_wb_* outputs are driven 0.
REQ-022 Ownership holds for as long as the owner's cyc stays high, which supports multi-beat bursts; other requests are ignored during this time.
REQ-023 When the owner's cyc falls, the arbiter returns to IDLE on the next edge and last_grant becomes the old owner; there is one mandatory idle cycle between owners.
REQ-024 In OWN, s_wb_ack_i and s_wb_err_i route only to the owner's ack/err bits; non-owners always see 0.
REQ-025 When s_wb_ack_i and s_wb_err_i are high in the same cycle, err wins and ack is suppressed.
REQ-026 m_wb_dat_o always equals s_wb_dat_i.
REQ-027 An 8-bit timeout counter increments each cycle s_wb_stb_o=1 with no ack or err from the slave, and clears on ack, on err, on stb=0, or in IDLE.
REQ-028 When the counter equals TIMEOUT, the owner's err bit pulses for 1 cycle and the counter clears.
REQ-029 During the timeout cycle, s_wb_stb_o is forced to 0; ownership is kept.
REQ-030 If the owner drops cyc with a transfer still outstanding, ownership is released per REQ-023, and any late slave ack in IDLE is discarded.

Reset
REQ-031 When rst_n is low: state=IDLE, last_grant=2 (master 0 wins first), timeout counter=0, grant_o=3, all s_wb_* outputs 0, all ack/err outputs 0.
REQ-032 Reset asserted mid-transfer aborts immediately: slave cyc/stb drop asynchronously and no ack is forwarded.

Verification
REQ-033 The bench shall cover these directed scenarios:
- Reset, then m0 alone requests a write of 0x0000AB60 to 0x3000_0000 -> slave sees it 1 cycle later, grant_o=0, ack routed to bit0 only.
- m0, m1 and m2 all hold cyc continuously, one beat each -> grants 0,1,2,0 with one idle cycle between owners.
- m1 runs a 4-beat burst while m2 requests -> grant_o=1 for all 4 beats, then m2 granted.
- Slave never acks, TIMEOUT=16 -> owner's err pulses once after 16 cycles of stb; s_wb_stb_o is 0 in that cycle.
- ack and err asserted together -> err_o=1 and ack_o=0 for the owner.
- rst_n low during an m2 read -> outputs 0 immediately, grant_o=3; after release, m0 wins a tie against m2.

Source files
------------

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: three masters share one slave, one owner at a time.
// Latency: request to slave 1 cycle; owner signals and slave response pass combinationally.
// Backpressure: owner keeps the slave until its cyc drops; others wait, with one idle cycle between owners.
module wb_rr_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [2:0]  m_wb_cyc_i,
    input  logic [2:0]  m_wb_stb_i,
    input  logic [2:0]  m_wb_we_i,
    input  logic [95:0] m_wb_adr_i,
    input  logic [95:0] m_wb_dat_i,
    input  logic [11:0] m_wb_sel_i,
    output logic [31:0] m_wb_dat_o,
    output logic [2:0]  m_wb_ack_o,
    output logic [2:0]  m_wb_err_o,
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_we_o,
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    output logic [3:0]  s_wb_sel_o,
    input  logic [31:0] s_wb_dat_i,
    input  logic        s_wb_ack_i,
    input  logic        s_wb_err_i,
    output logic [1:0]  grant_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_OWN    = 1'b1;
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    localparam logic [1:0] NO_OWNER  = 2'd3;

    logic [0:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        own;
    logic        tmo;
    logic [1:0]  cand0, cand1, cand2, pick;
    logic        sel_cyc, sel_stb, sel_we;
    logic [31:0] sel_adr, sel_dat;
    logic [3:0]  sel_sel;
    logic [2:0]  owner_onehot;
    logic        ack_fwd, err_fwd;

    // Next index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign own = (state_q == ST_OWN);
    // Timeout cycle: owner gets an error and the strobe is withheld for one cycle.
    assign tmo = own && (cnt_q == TMO_LIMIT);

    // Round-robin candidate order starts just after the previous owner.
    always_comb begin
        cand0 = rr_next(last_q);
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        pick  = cand2;
        if (m_wb_cyc_i[cand0]) begin
            pick = cand0;
        end else if (m_wb_cyc_i[cand1]) begin
            pick = cand1;
        end
    end

    // Select the current owner's bus signals.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        sel_sel = '0;
        case (owner_q)
            2'd0: begin
                sel_cyc = m_wb_cyc_i[0];
                sel_stb = m_wb_stb_i[0];
                sel_we  = m_wb_we_i[0];
                sel_adr = m_wb_adr_i[31:0];
                sel_dat = m_wb_dat_i[31:0];
                sel_sel = m_wb_sel_i[3:0];
            end
            2'd1: begin
                sel_cyc = m_wb_cyc_i[1];
                sel_stb = m_wb_stb_i[1];
                sel_we  = m_wb_we_i[1];
                sel_adr = m_wb_adr_i[63:32];
                sel_dat = m_wb_dat_i[63:32];
                sel_sel = m_wb_sel_i[7:4];
            end
            2'd2: begin
                sel_cyc = m_wb_cyc_i[2];
                sel_stb = m_wb_stb_i[2];
                sel_we  = m_wb_we_i[2];
                sel_adr = m_wb_adr_i[95:64];
                sel_dat = m_wb_dat_i[95:64];
                sel_sel = m_wb_sel_i[11:8];
            end
            default: begin
                sel_cyc = 1'b0;
            end
        endcase
    end

    // Slave side is driven only while someone owns it; otherwise all zero.
    assign s_wb_cyc_o = own & sel_cyc;
    assign s_wb_stb_o = own & sel_stb & ~tmo;
    assign s_wb_we_o  = own & sel_we;
    assign s_wb_adr_o = own ? sel_adr : 32'd0;
    assign s_wb_dat_o = own ? sel_dat : 32'd0;
    assign s_wb_sel_o = own ? sel_sel : 4'd0;

    // Response goes to the owner only; error (slave or timeout) beats ack.
    assign owner_onehot = 3'b001 << owner_q;
    assign err_fwd      = own & (s_wb_err_i | tmo);
    assign ack_fwd      = own & s_wb_ack_i & ~s_wb_err_i & ~tmo;
    assign m_wb_err_o   = err_fwd ? owner_onehot : 3'b000;
    assign m_wb_ack_o   = ack_fwd ? owner_onehot : 3'b000;
    assign m_wb_dat_o   = s_wb_dat_i;
    assign grant_o      = own ? owner_q : NO_OWNER;

    // Ownership FSM and stall counter next-state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (s_wb_stb_o && !s_wb_ack_i && !s_wb_err_i) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
        if (state_q == ST_IDLE) begin
            if (|m_wb_cyc_i) begin
                state_d = ST_OWN;
                owner_d = pick;
            end
        end else if (!sel_cyc) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
        end
    end

    // State registers; reset leaves master 0 first in line.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arb.sv
// Self-checking bench for wb_rr_arb: directed scenarios, then randomized traffic.
// Every negedge a queue/array-level reference model predicts all outputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wb_rr_arb;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  m_wb_cyc_i = '0;
    logic [2:0]  m_wb_stb_i = '0;
    logic [2:0]  m_wb_we_i  = '0;
    logic [95:0] m_wb_adr_i = '0;
    logic [95:0] m_wb_dat_i = '0;
    logic [11:0] m_wb_sel_i = '0;
    logic [31:0] m_wb_dat_o;
    logic [2:0]  m_wb_ack_o;
    logic [2:0]  m_wb_err_o;
    logic        s_wb_cyc_o;
    logic        s_wb_stb_o;
    logic        s_wb_we_o;
    logic [31:0] s_wb_adr_o;
    logic [31:0] s_wb_dat_o;
    logic [3:0]  s_wb_sel_o;
    logic [31:0] s_wb_dat_i = '0;
    logic        s_wb_ack_i = 1'b0;
    logic        s_wb_err_i = 1'b0;
    logic [1:0]  grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner (-1 = none), last owner, stall count.
    int mo = -1;
    int ml = 2;
    int mc = 0;

    wb_rr_arb #(.TIMEOUT(TMO)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .m_wb_cyc_i (m_wb_cyc_i),
        .m_wb_stb_i (m_wb_stb_i),
        .m_wb_we_i  (m_wb_we_i),
        .m_wb_adr_i (m_wb_adr_i),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_sel_i (m_wb_sel_i),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_ack_o (m_wb_ack_o),
        .m_wb_err_o (m_wb_err_o),
        .s_wb_cyc_o (s_wb_cyc_o),
        .s_wb_stb_o (s_wb_stb_o),
        .s_wb_we_o  (s_wb_we_o),
        .s_wb_adr_o (s_wb_adr_o),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_sel_o (s_wb_sel_o),
        .s_wb_dat_i (s_wb_dat_i),
        .s_wb_ack_i (s_wb_ack_i),
        .s_wb_err_i (s_wb_err_i),
        .grant_o    (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid;
        @(negedge clk_i);
    endtask

    task automatic clear_inputs;
        m_wb_cyc_i = '0;
        m_wb_stb_i = '0;
        m_wb_we_i  = '0;
        s_wb_ack_i = 1'b0;
        s_wb_err_i = 1'b0;
    endtask

    // Reference model: predict outputs from the rules, then advance one cycle.
    always @(negedge clk_i) begin : ref_model
        int          o;
        bit          own;
        bit          t;
        logic        e_cyc, e_stb, e_we;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic [2:0]  e_ack, e_err;
        if (!rst_n) begin
            mo = -1;
            ml = 2;
            mc = 0;
        end
        own   = (mo >= 0);
        o     = own ? mo : 0;
        t     = own && (mc == TMO);
        e_cyc = own && m_wb_cyc_i[o];
        e_stb = own && m_wb_stb_i[o] && !t;
        e_we  = own && m_wb_we_i[o];
        e_adr = own ? m_wb_adr_i[o*32 +: 32] : 32'd0;
        e_dat = own ? m_wb_dat_i[o*32 +: 32] : 32'd0;
        e_sel = own ? m_wb_sel_i[o*4 +: 4] : 4'd0;
        e_ack = '0;
        e_err = '0;
        if (own && (s_wb_err_i || t)) e_err[o] = 1'b1;
        else if (own && s_wb_ack_i)   e_ack[o] = 1'b1;

        check("mdl_grant", 32'(grant_o), own ? 32'(o) : 32'd3);
        check("mdl_s_cyc", 32'(s_wb_cyc_o), 32'(e_cyc));
        check("mdl_s_stb", 32'(s_wb_stb_o), 32'(e_stb));
        check("mdl_s_we",  32'(s_wb_we_o),  32'(e_we));
        check("mdl_s_adr", s_wb_adr_o, e_adr);
        check("mdl_s_dat", s_wb_dat_o, e_dat);
        check("mdl_s_sel", 32'(s_wb_sel_o), 32'(e_sel));
        check("mdl_m_ack", 32'(m_wb_ack_o), 32'(e_ack));
        check("mdl_m_err", 32'(m_wb_err_o), 32'(e_err));
        check("mdl_m_dat", m_wb_dat_o, s_wb_dat_i);

        if (rst_n) begin
            if (!own) begin
                for (int k = 1; k <= 3; k++) begin
                    if (mo < 0 && m_wb_cyc_i[(ml + k) % 3]) begin
                        mo = (ml + k) % 3;
                        mc = 0;
                    end
                end
            end else if (!m_wb_cyc_i[o]) begin
                ml = o;
                mo = -1;
                mc = 0;
            end else if (e_stb && !s_wb_ack_i && !s_wb_err_i) begin
                mc++;
            end else begin
                mc = 0;
            end
        end
    end

    initial begin : stim
        logic [1:0]  g;
        logic [1:0]  prev;
        int          seen;
        logic [31:0] exp_seq [4];
        bit          sticky;
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd0};

        // Reset state
        mid;
        check("rst_grant", 32'(grant_o), 32'd3);
        check("rst_s_cyc", 32'(s_wb_cyc_o), 32'd0);
        check("rst_acks",  32'({m_wb_ack_o, m_wb_err_o}), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        // m0 single write
        tick;
        m_wb_cyc_i[0] = 1'b1;
        m_wb_stb_i[0] = 1'b1;
        m_wb_we_i[0]  = 1'b1;
        m_wb_adr_i[31:0] = 32'h3000_0000;
        m_wb_dat_i[31:0] = 32'h0000_AB60;
        m_wb_sel_i[3:0]  = 4'hF;
        mid;
        check("wr_latency_cyc", 32'(s_wb_cyc_o), 32'd0);
        tick;
        s_wb_ack_i = 1'b1;
        mid;
        check("wr_grant", 32'(grant_o), 32'd0);
        check("wr_s_cyc", 32'(s_wb_cyc_o), 32'd1);
        check("wr_s_we",  32'(s_wb_we_o), 32'd1);
        check("wr_s_adr", s_wb_adr_o, 32'h3000_0000);
        check("wr_s_dat", s_wb_dat_o, 32'h0000_AB60);
        check("wr_ack",   32'(m_wb_ack_o), 32'b001);
        tick;
        clear_inputs;
        tick;
        tick;

        // Fresh reset, then all three masters compete
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        m_wb_cyc_i = 3'b111;
        m_wb_stb_i = 3'b111;
        prev = 2'd3;
        seen = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            mid;
            g = grant_o;
            if (g != 2'd3 && g != prev) begin
                check("rr_idle_gap", 32'(prev), 32'd3);
                check("rr_order", 32'(g), exp_seq[seen]);
                seen++;
            end
            prev = g;
            tick;
            if (g != 2'd3) begin
                if (!s_wb_ack_i) begin
                    s_wb_ack_i = 1'b1;
                end else begin
                    s_wb_ack_i    = 1'b0;
                    m_wb_cyc_i[g] = 1'b0;
                    m_wb_stb_i[g] = 1'b0;
                end
            end else begin
                m_wb_cyc_i = 3'b111;
                m_wb_stb_i = 3'b111;
            end
        end
        if (seen < 4) check("rr_grants_seen", 32'(seen), 32'd4);
        clear_inputs;
        tick;
        tick;
        tick;

        // m1 4-beat burst while m2 waits
        m_wb_cyc_i = 3'b110;
        m_wb_stb_i = 3'b110;
        s_wb_ack_i = 1'b1;
        mid;
        check("burst_idle_ack_drop", 32'(m_wb_ack_o), 32'd0);
        check("burst_idle_grant", 32'(grant_o), 32'd3);
        for (int b = 0; b < 4; b++) begin
            tick;
            mid;
            check("burst_grant", 32'(grant_o), 32'd1);
            check("burst_ack", 32'(m_wb_ack_o), 32'b010);
        end
        tick;
        m_wb_cyc_i[1] = 1'b0;
        m_wb_stb_i[1] = 1'b0;
        s_wb_ack_i    = 1'b0;
        mid;
        check("burst_release_grant", 32'(grant_o), 32'd1);
        tick;
        mid;
        check("burst_gap_grant", 32'(grant_o), 32'd3);
        tick;
        mid;
        check("burst_next_grant", 32'(grant_o), 32'd2);
        tick;
        clear_inputs;
        tick;
        tick;

        // Slave never responds: timeout after 16 strobe cycles
        m_wb_cyc_i[0] = 1'b1;
        m_wb_stb_i[0] = 1'b1;
        mid;
        for (int c = 1; c <= TMO; c++) begin
            tick;
            mid;
            check("tmo_wait_stb", 32'(s_wb_stb_o), 32'd1);
            check("tmo_wait_err", 32'(m_wb_err_o), 32'd0);
        end
        tick;
        mid;
        check("tmo_err", 32'(m_wb_err_o), 32'b001);
        check("tmo_stb_forced", 32'(s_wb_stb_o), 32'd0);
        check("tmo_grant_kept", 32'(grant_o), 32'd0);
        tick;
        mid;
        check("tmo_err_single", 32'(m_wb_err_o), 32'd0);
        check("tmo_stb_back", 32'(s_wb_stb_o), 32'd1);
        tick;
        clear_inputs;
        tick;
        tick;

        // ack and err together: err wins
        m_wb_cyc_i[1] = 1'b1;
        m_wb_stb_i[1] = 1'b1;
        mid;
        tick;
        s_wb_ack_i = 1'b1;
        s_wb_err_i = 1'b1;
        mid;
        check("both_grant", 32'(grant_o), 32'd1);
        check("both_err", 32'(m_wb_err_o), 32'b010);
        check("both_ack", 32'(m_wb_ack_o), 32'd0);
        tick;
        clear_inputs;
        tick;
        tick;

        // Reset during m2 read, then m0 beats m2 on a tie
        m_wb_cyc_i[2] = 1'b1;
        m_wb_stb_i[2] = 1'b1;
        mid;
        tick;
        mid;
        check("rd2_grant", 32'(grant_o), 32'd2);
        tick;
        s_wb_ack_i = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("arst_s_cyc", 32'(s_wb_cyc_o), 32'd0);
        check("arst_s_stb", 32'(s_wb_stb_o), 32'd0);
        check("arst_grant", 32'(grant_o), 32'd3);
        check("arst_ack", 32'(m_wb_ack_o), 32'd0);
        s_wb_ack_i = 1'b0;
        m_wb_cyc_i = 3'b101;
        m_wb_stb_i = 3'b101;
        tick;
        tick;
        rst_n = 1'b1;
        mid;
        check("post_rst_idle", 32'(grant_o), 32'd3);
        tick;
        mid;
        check("post_rst_tie", 32'(grant_o), 32'd0);
        tick;
        clear_inputs;
        tick;
        tick;

        // Randomized traffic, alternating normal and stalling-slave windows
        for (int c = 0; c < 3000; c++) begin
            tick;
            sticky = ((c / 200) % 2) == 1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            for (int m = 0; m < 3; m++) begin
                if (m_wb_cyc_i[m]) begin
                    if ($urandom_range(0, sticky ? 40 : 5) == 0) m_wb_cyc_i[m] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_wb_cyc_i[m] = 1'b1;
                end
                m_wb_stb_i[m] = sticky ? 1'b1 : ($urandom_range(0, 3) != 0);
                m_wb_we_i[m]  = ($urandom_range(0, 1) == 1);
            end
            m_wb_adr_i = {$urandom(), $urandom(), $urandom()};
            m_wb_dat_i = {$urandom(), $urandom(), $urandom()};
            m_wb_sel_i = 12'($urandom());
            s_wb_dat_i = $urandom();
            s_wb_ack_i = sticky ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 2) == 0);
            s_wb_err_i = sticky ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 15) == 0);
        end
        tick;
        mid;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
